// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable integer clock divider with glitch-free start/stop
// and a one-deep ratio queue that is applied only on period boundaries.
module clk_div_ctrl #(
  parameter int WIDTH         = 8,
  parameter int DEFAULT_RATIO = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_ratio,
  output logic             div_ready,
  output logic             div_err,
  output logic             out_clk,
  output logic             out_tick,
  output logic [WIDTH-1:0] cur_ratio,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] RATIO_RST = WIDTH'(DEFAULT_RATIO);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);

  state_t           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cur_ratio_q;
  logic [WIDTH-1:0] pend_q;
  logic             pend_full_q;
  logic             out_clk_q;
  logic             out_tick_q;
  logic             div_err_q;

  logic             accept;
  logic             legal;
  logic             take;
  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap;

  assign accept = div_valid && !pend_full_q;
  assign legal  = (div_ratio >= TWO);
  assign take   = accept && legal;
  assign half   = cur_ratio_q >> 1;
  assign cnt_d  = cnt_q + ONE;
  assign wrap   = (cnt_q == (cur_ratio_q - ONE));

  // en sampled on the wrap edge decides whether a new period starts or the divider parks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cur_ratio_q <= RATIO_RST;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      out_clk_q   <= 1'b0;
      out_tick_q  <= 1'b0;
      div_err_q   <= 1'b0;
    end else begin
      out_tick_q <= 1'b0;
      div_err_q  <= accept && !legal;
      case (state_q)
        ST_IDLE: begin
          cnt_q     <= '0;
          out_clk_q <= 1'b0;
          if (take) begin
            cur_ratio_q <= div_ratio;
          end
          if (en) begin
            state_q    <= ST_RUN;
            out_clk_q  <= 1'b1;
            out_tick_q <= 1'b1;
          end
        end
        default: begin
          if (wrap) begin
            cnt_q <= '0;
            // take implies the queue is empty, so it never collides with this drain.
            if (pend_full_q) begin
              cur_ratio_q <= pend_q;
              pend_full_q <= 1'b0;
            end
            if (en) begin
              state_q    <= ST_RUN;
              out_clk_q  <= 1'b1;
              out_tick_q <= 1'b1;
              if (take) begin
                pend_q      <= div_ratio;
                pend_full_q <= 1'b1;
              end
            end else begin
              state_q   <= ST_IDLE;
              out_clk_q <= 1'b0;
              if (take) begin
                cur_ratio_q <= div_ratio;
              end
            end
          end else begin
            cnt_q   <= cnt_d;
            state_q <= en ? ST_RUN : ST_STOP;
            if (cnt_d == half) begin
              out_clk_q <= 1'b0;
            end
            if (take) begin
              pend_q      <= div_ratio;
              pend_full_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign div_ready = !pend_full_q;
  assign div_err   = div_err_q;
  assign out_clk   = out_clk_q;
  assign out_tick  = out_tick_q;
  assign cur_ratio = cur_ratio_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - randomized bench for clk_div_ctrl against a period-position model
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       div_valid;
  logic [7:0] div_ratio;
  logic       div_ready;
  logic       div_err;
  logic       out_clk;
  logic       out_tick;
  logic [7:0] cur_ratio;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  clk_div_ctrl #(.WIDTH(8), .DEFAULT_RATIO(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .div_valid (div_valid),
    .div_ratio (div_ratio),
    .div_ready (div_ready),
    .div_err   (div_err),
    .out_clk   (out_clk),
    .out_tick  (out_tick),
    .cur_ratio (cur_ratio),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Model: a period is described by its ratio and the cycle position within it.
  bit m_active;
  int m_pos;
  int m_n;
  int m_pend[$];
  bit m_tick;
  bit m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_pos    = 0;
    m_n      = 2;
    m_pend.delete();
    m_tick   = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_edge(input bit e, input bit v, input int r);
    bit acc;
    bit ok;
    acc    = v && (m_pend.size() == 0);
    ok     = acc && (r >= 2);
    m_tick = 1'b0;
    m_err  = acc && (r < 2);
    if (!m_active) begin
      if (ok) m_n = r;
      if (e) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_tick   = 1'b1;
      end
    end else if (m_pos == m_n - 1) begin
      if (m_pend.size() != 0) m_n = m_pend.pop_front();
      m_pos = 0;
      if (e) begin
        m_tick = 1'b1;
        if (ok) m_pend.push_back(r);
      end else begin
        m_active = 1'b0;
        if (ok) m_n = r;
      end
    end else begin
      m_pos++;
      if (ok) m_pend.push_back(r);
    end
  endtask

  task automatic check_outputs();
    check_eq("out_clk",   32'(out_clk),   32'(m_active && (m_pos < m_n / 2)));
    check_eq("out_tick",  32'(out_tick),  32'(m_tick));
    check_eq("div_err",   32'(div_err),   32'(m_err));
    check_eq("cur_ratio", 32'(cur_ratio), 32'(m_n));
    check_eq("busy",      32'(busy),      32'(m_active));
    check_eq("div_ready", 32'(div_ready), 32'(m_pend.size() == 0));
  endtask

  task automatic step(input bit e, input bit v, input int r);
    en        = e;
    div_valid = v;
    div_ratio = r[7:0];
    model_edge(e, v, r);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    bit e_r;
    int guard;
    rst_n     = 1'b0;
    en        = 1'b0;
    div_valid = 1'b0;
    div_ratio = '0;
    model_reset();
    #7;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Default ratio 2 straight out of reset, quiet while en is low.
    repeat (2) step(1'b0, 1'b0, 0);
    repeat (10) step(1'b1, 1'b0, 0);
    repeat (4) step(1'b0, 1'b0, 0);

    // Ratio 5 loaded while idle, then illegal writes while running.
    step(1'b0, 1'b1, 5);
    repeat (12) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 0);
    repeat (6) step(1'b1, 1'b0, 0);

    // Ratio change mid-period and stop/restart without a gap.
    step(1'b1, 1'b1, 4);
    repeat (10) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 7);
    repeat (20) step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    repeat (3) step(1'b0, 1'b0, 0);
    repeat (10) step(1'b1, 1'b0, 0);

    e_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) e_r = !e_r;
      step(e_r, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 12)));
    end

    // Asynchronous reset while out_clk is high with ratio 8 and a pending write.
    guard = 0;
    while (m_active && guard < 300) begin
      step(1'b0, 1'b0, 0);
      guard++;
    end
    check_eq("drain_to_idle", 32'(m_active), 32'(0));
    step(1'b0, 1'b1, 8);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 3);
    check_eq("pre_rst_out_clk", 32'(out_clk), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 0);
    repeat (8) step(1'b1, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, width of division ratio fields.
REQ-002 Parameter DEFAULT_RATIO, default 2, active ratio after reset; legal range 2..2^WIDTH-1.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  run request for divided clock.
REQ-006 div_valid  input  1  new ratio offered.
REQ-007 div_ratio  input  WIDTH  offered ratio N, sampled when div_valid && div_ready.
REQ-008 div_ready  output  1  ratio can be accepted; combinational, equal to NOT pending_full.
REQ-009 div_err  output  1  one-cycle pulse: accepted ratio was illegal (<2) and discarded.
REQ-010 out_clk  output  1  divided clock, registered, glitch-free.
REQ-011 out_tick  output  1  one-cycle pulse, high in the cycle out_clk first reads 1 of each period.
REQ-012 cur_ratio  output  WIDTH  ratio currently in effect.
REQ-013 busy  output  1  high in RUN or STOP.

Function
REQ-014 States: IDLE, RUN, STOP; internal counter cnt (WIDTH bits), one-deep pending ratio register with pending_full flag.
REQ-015 Period: N = cur_ratio; H = N>>1; out_clk high for H cycles, low for N-H cycles (N=2: 1/1, N=3: 1/2, N=5: 2/3).
REQ-016 IDLE: out_clk=0, cnt=0; en=1 at edge -> RUN, out_clk=1, out_tick=1, cnt=0 after that edge (one-cycle latency).
REQ-017 RUN/STOP each edge: if cnt==N-1 -> cnt=0 (wrap); else cnt=cnt+1; out_clk cleared on the edge where cnt+1==H, set on wrap (RUN only).
REQ-018 Wrap in RUN: out_clk=1, out_tick=1; if pending_full, cur_ratio<=pending, pending_full<=0 on same edge, new period uses new N.
REQ-019 en=0 in RUN -> STOP; current period completes unchanged (no runt pulse).
REQ-020 Wrap in STOP: -> IDLE, out_clk stays 0, cnt=0, out_tick=0; pending applied as in REQ-018.
REQ-021 en=1 in STOP -> RUN with no period interruption; next wrap behaves per REQ-018.
REQ-022 Handshake: transfer when div_valid && div_ready at edge; div_ratio<2 -> div_err=1 next cycle, no state change.
REQ-023 Legal transfer in IDLE: cur_ratio<=div_ratio directly, pending untouched.
REQ-024 Legal transfer in RUN/STOP: pending<=div_ratio, pending_full<=1, div_ready=0 until applied, including transfer on a wrap edge (applied at next wrap).
REQ-025 Legal transfer on the edge IDLE->RUN: cur_ratio<=div_ratio, first period uses it.
REQ-026 Pending_full while entering IDLE is impossible (REQ-020 drains it); div_ready=1 whenever IDLE.
REQ-027 Ratio change never alters H or N mid-period; out_clk high/low widths of every period exactly match the ratio in effect at that period's start.

Reset
REQ-028 rst_n low asynchronously forces: IDLE, cnt=0, cur_ratio=DEFAULT_RATIO, pending_full=0, out_clk=0, out_tick=0, div_err=0, busy=0.
REQ-029 Reset asserted mid-period terminates out_clk immediately to 0; release takes effect at first rising clk edge with rst_n high, no pulses before en sampled high.

Verification
REQ-030 Reset, en=1 after release, DEFAULT_RATIO=2 -> out_clk toggles every clk, out_tick every 2nd cycle, cur_ratio=2.
REQ-031 IDLE, write ratio 5, en=1 -> out_clk 2 high/3 low repeating, out_tick period 5, busy=1.
REQ-032 Running N=4, write 7 mid-period -> div_ready=0 until next wrap; current period 2/2, following periods 3/4, cur_ratio=7 from wrap.
REQ-033 Write ratio 1 and 0 -> div_err pulses one cycle each, cur_ratio unchanged, out_clk unaffected.
REQ-034 Running N=6, drop en at cnt=1 -> period finishes (3 high/3 low total), then IDLE, out_clk=0, busy=0; re-raise en during STOP -> continuous periods, no gap.
REQ-035 Assert rst_n=0 while out_clk=1, N=8 -> out_clk=0 immediately, cur_ratio=DEFAULT_RATIO, pending cleared, div_ready=1.
